// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall/flush control and MADD/MSUB accumulate feedback.
// Optional HI/LO write-back path is present only when `EXMEM_HILO_EN is defined.
module ex_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
`ifdef EXMEM_HILO_EN
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
`endif
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
`ifdef EXMEM_HILO_EN
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
`endif
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [CNT_W-1:0]    cnt_o
);

  typedef enum logic [1:0] {
    MODE_CAPTURE,
    MODE_BUBBLE,
    MODE_HOLD,
    MODE_CLEAR
  } mode_e;

  mode_e mode;

  logic [ADDR_W-1:0]   wd_q,    wd_d;
  logic                wreg_q,  wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2*DATA_W-1:0] hilo_q,  hilo_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
`ifdef EXMEM_HILO_EN
  logic                whilo_q, whilo_d;
  logic [DATA_W-1:0]   hi_q,    hi_d;
  logic [DATA_W-1:0]   lo_q,    lo_d;
`endif

  // Flush beats any stall; stall[4] without stall[3] is treated as a plain capture.
  always_comb begin
    if (flush)
      mode = MODE_CLEAR;
    else if (stall[3] && stall[4])
      mode = MODE_HOLD;
    else if (stall[3])
      mode = MODE_BUBBLE;
    else
      mode = MODE_CAPTURE;
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
`ifdef EXMEM_HILO_EN
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`endif
    unique case (mode)
      MODE_CLEAR: begin
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = '0;
        hilo_d  = '0;
        cnt_d   = '0;
`ifdef EXMEM_HILO_EN
        whilo_d = 1'b0;
        hi_d    = '0;
        lo_d    = '0;
`endif
      end
      MODE_BUBBLE: begin
        // NOP goes to MEM while the partial accumulate step is parked here for EX.
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = '0;
        hilo_d  = hilo_i;
        cnt_d   = cnt_i;
`ifdef EXMEM_HILO_EN
        whilo_d = 1'b0;
        hi_d    = '0;
        lo_d    = '0;
`endif
      end
      MODE_HOLD: begin
      end
      default: begin
        wd_d    = ex_wd;
        wreg_d  = ex_wreg;
        wdata_d = ex_wdata;
        hilo_d  = '0;
        cnt_d   = '0;
`ifdef EXMEM_HILO_EN
        whilo_d = ex_whilo;
        hi_d    = ex_hi;
        lo_d    = ex_lo;
`endif
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hilo_q  <= '0;
      cnt_q   <= '0;
`ifdef EXMEM_HILO_EN
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`endif
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
`ifdef EXMEM_HILO_EN
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`endif
    end
  end

  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;
`ifdef EXMEM_HILO_EN
  assign mem_whilo = whilo_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for ex_mem; HI/LO checks compile in with `EXMEM_HILO_EN.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
`ifdef EXMEM_HILO_EN
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
`ifdef EXMEM_HILO_EN
    .ex_whilo  (ex_whilo),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
`endif
    .hilo_i    (hilo_i),
    .cnt_i     (cnt_i),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
`ifdef EXMEM_HILO_EN
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
`endif
    .hilo_o    (hilo_o),
    .cnt_o     (cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [63:0] hilo, input logic [1:0] cnt);
    ex_wd    = wd;
    ex_wreg  = wreg;
    ex_wdata = wdata;
    hilo_i   = hilo;
    cnt_i    = cnt;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wd"},    64'(mem_wd),    64'd0);
    check({tag, ".wreg"},  64'(mem_wreg),  64'd0);
    check({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, ".hilo"},  hilo_o,         64'd0);
    check({tag, ".cnt"},   64'(cnt_o),     64'd0);
`ifdef EXMEM_HILO_EN
    check({tag, ".whilo"}, 64'(mem_whilo), 64'd0);
    check({tag, ".hi"},    64'(mem_hi),    64'd0);
    check({tag, ".lo"},    64'(mem_lo),    64'd0);
`endif
  endtask

  logic [4:0]  s_wd   [3] = '{5'd1, 5'd17, 5'd31};
  logic [31:0] s_data [3] = '{32'h0000_0001, 32'hCAFE_F00D, 32'hFFFF_FFFF};

  initial begin
    rst = 1'b1;
    stall = 6'b0;
    flush = 1'b0;
    drive(5'd0, 1'b0, 32'd0, 64'd0, 2'd0);
`ifdef EXMEM_HILO_EN
    ex_whilo = 1'b0;
    ex_hi    = 32'd0;
    ex_lo    = 32'd0;
`endif

    // Reset held for two edges with random EX traffic and random stall.
    for (int i = 0; i < 2; i++) begin
      drive(5'($urandom), 1'b1, $urandom, {$urandom, $urandom}, 2'($urandom));
      stall = 6'($urandom);
`ifdef EXMEM_HILO_EN
      ex_whilo = 1'b1;
      ex_hi    = $urandom;
      ex_lo    = $urandom;
`endif
      step();
      check_all_zero($sformatf("rst%0d", i));
    end

    rst = 1'b0;
    stall = 6'b0;
`ifdef EXMEM_HILO_EN
    ex_whilo = 1'b0;
`endif
    drive(5'd5, 1'b1, 32'hDEADBEEF, 64'd0, 2'd0);
    step();
    check("post_rst.wd",    64'(mem_wd),    64'd5);
    check("post_rst.wreg",  64'(mem_wreg),  64'd1);
    check("post_rst.wdata", 64'(mem_wdata), 64'hDEADBEEF);

    // Streaming capture: value visible only after the edge, in order.
    for (int i = 0; i < 3; i++) begin
      drive(s_wd[i], 1'b1, s_data[i], 64'd0, 2'd0);
      #1;
      check($sformatf("stream%0d.pre", i), 64'(mem_wdata), (i == 0) ? 64'hDEADBEEF : 64'(s_data[i-1]));
      step();
      check($sformatf("stream%0d.wd", i),    64'(mem_wd),    64'(s_wd[i]));
      check($sformatf("stream%0d.wdata", i), 64'(mem_wdata), 64'(s_data[i]));
    end

    // BUBBLE: NOP to MEM, accumulate step saved.
    stall = 6'b001000;
    drive(5'd9, 1'b1, 32'h5555_AAAA, 64'h1_0000_0002, 2'd1);
    step();
    check("bubble.wd",    64'(mem_wd),    64'd0);
    check("bubble.wreg",  64'(mem_wreg),  64'd0);
    check("bubble.wdata", 64'(mem_wdata), 64'd0);
    check("bubble.hilo",  hilo_o,         64'h1_0000_0002);
    check("bubble.cnt",   64'(cnt_o),     64'd1);

    // Capture then HOLD for 3 edges while EX inputs change.
    stall = 6'b0;
    drive(5'd12, 1'b1, 32'h12345678, 64'hFFFF, 2'd3);
    step();
    check("cap.wdata", 64'(mem_wdata), 64'h12345678);
    check("cap.hilo",  hilo_o,         64'd0);
    check("cap.cnt",   64'(cnt_o),     64'd0);
    stall = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      drive(5'(i + 20), 1'b0, 32'h0BAD_0000 + 32'(i), 64'h7777_0000 + 64'(i), 2'd1);
      step();
      check($sformatf("hold%0d.wd", i),    64'(mem_wd),    64'd12);
      check($sformatf("hold%0d.wdata", i), 64'(mem_wdata), 64'h12345678);
      check($sformatf("hold%0d.hilo", i),  hilo_o,         64'd0);
      check($sformatf("hold%0d.cnt", i),   64'(cnt_o),     64'd0);
    end

    // Saved accumulate state survives a HOLD; cnt passes 3 unchanged.
    stall = 6'b001000;
    drive(5'd0, 1'b0, 32'd0, 64'hABCD_0123_4567_89EF, 2'd3);
    step();
    check("bub2.cnt", 64'(cnt_o), 64'd3);
    stall = 6'b011000;
    drive(5'd0, 1'b0, 32'd0, 64'h1111_2222_3333_4444, 2'd2);
    step();
    check("hold_acc.hilo", hilo_o,     64'hABCD_0123_4567_89EF);
    check("hold_acc.cnt",  64'(cnt_o), 64'd3);

    // Flush beats BUBBLE and wipes the accumulate state.
    stall = 6'b001000;
    flush = 1'b1;
    drive(5'd7, 1'b1, 32'h7777_7777, 64'h9, 2'd1);
    step();
    check_all_zero("flush");
    flush = 1'b0;
    stall = 6'b0;
    drive(5'd3, 1'b1, 32'h0000_BEEF, 64'h9, 2'd1);
    step();
    check("after_flush.wd",    64'(mem_wd),    64'd3);
    check("after_flush.wdata", 64'(mem_wdata), 64'h0000_BEEF);
    check("after_flush.cnt",   64'(cnt_o),     64'd0);

    // Illegal stall[4] without stall[3] acts as CAPTURE.
    stall = 6'b010000;
    drive(5'd30, 1'b0, 32'h0F0F_0F0F, 64'h5, 2'd2);
    step();
    check("illegal.wd",    64'(mem_wd),    64'd30);
    check("illegal.wreg",  64'(mem_wreg),  64'd0);
    check("illegal.wdata", 64'(mem_wdata), 64'h0F0F_0F0F);
    check("illegal.hilo",  hilo_o,         64'd0);

`ifdef EXMEM_HILO_EN
    stall = 6'b0;
    ex_whilo = 1'b1;
    ex_hi    = 32'hA;
    ex_lo    = 32'hB;
    step();
    check("hilo.whilo", 64'(mem_whilo), 64'd1);
    check("hilo.hi",    64'(mem_hi),    64'hA);
    check("hilo.lo",    64'(mem_lo),    64'hB);
    stall = 6'b011000;
    ex_hi = 32'hC;
    step();
    check("hilo_hold.hi", 64'(mem_hi), 64'hA);
    stall = 6'b001000;
    step();
    check("hilo_bub.whilo", 64'(mem_whilo), 64'd0);
    check("hilo_bub.hi",    64'(mem_hi),    64'd0);
`endif

    // Reset in the middle of a multi-cycle step clears it in the same cycle.
    stall = 6'b001000;
    drive(5'd0, 1'b0, 32'd0, 64'h42, 2'd1);
    step();
    check("pre_rst.cnt", 64'(cnt_o), 64'd1);
    rst = 1'b1;
    step();
    check_all_zero("mid_rst");
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
